kbd_arrow_decoder: RTL and testbench

KBD_ARROW_DECODER -- requirements
Module: kbd_arrow_decoder

---
 rtl/kbd_arrow_decoder.sv | 88 ++++++++
 tb/tb_kbd_arrow_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/kbd_arrow_decoder.sv
// kbd_arrow_decoder: PS/2 set-2 decoder tracking the four arrows, space and enter as held levels.
// Optional macro KBD_ONE_HOT_EN: only the most recently made arrow is driven on the arrow outputs.
module kbd_arrow_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       din_new,
   input  logic [7:0] din,
   output logic       leftArrowPressed,
   output logic       rightArrowPressed,
   output logic       downArrowPressed,
   output logic       upArrowPressed,
   output logic       spacePressed,
   output logic       enterPressed,
   output logic       keyStrobe
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_EXT     = 2'd1;
   localparam logic [1:0] S_BRK     = 2'd2;
   localparam logic [1:0] S_EXT_BRK = 2'd3;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [5:0]    r_held, w_key, w_held_nxt;
   logic          r_strobe, w_ext, w_brk, w_final, w_hit;

   // held bit order: 0 left, 1 right, 2 down, 3 up, 4 space, 5 enter
   assign w_ext      = r_state == S_EXT || r_state == S_EXT_BRK;
   assign w_brk      = r_state == S_BRK || r_state == S_EXT_BRK;
   assign w_final    = din_new && !(r_state == S_IDLE && (din == 8'hE0 || din == 8'hF0))
                               && !(r_state == S_EXT && din == 8'hF0);
   assign w_key      = w_ext ? {2'b00, din == 8'h75, din == 8'h72, din == 8'h74, din == 8'h6B}
                             : {din == 8'h5A, din == 8'h29, 4'b0000};
   assign w_hit      = w_final && |w_key;
   assign w_held_nxt = !w_hit ? r_held : w_brk ? r_held & ~w_key : r_held | w_key;

   // prefix bytes advance the FSM, any other byte finishes the sequence; a stale prefix times out to IDLE
   always_comb begin
      w_state_nxt = r_state;
      if (din_new)
         w_state_nxt = r_state == S_IDLE ? (din == 8'hE0 ? S_EXT : din == 8'hF0 ? S_BRK : S_IDLE)
                     : (r_state == S_EXT && din == 8'hF0) ? S_EXT_BRK : S_IDLE;
      else if (r_state != S_IDLE && r_cnt == TMAX)
         w_state_nxt = S_IDLE;
   end

   // FSM state, timeout counter, held-key levels and the make/break strobe
   always_ff @(posedge clk) begin
      if (resetN) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_held   <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= (din_new || r_state == S_IDLE || r_cnt == TMAX) ? '0 : r_cnt + 1'b1;
         r_held   <= w_held_nxt;
         r_strobe <= w_hit;
      end
   end

`ifdef KBD_ONE_HOT_EN
   logic [3:0] r_drv, w_fall;

   // fallback when the driven arrow is released: up > down > left > right
   assign w_fall = w_held_nxt[3] ? 4'b1000 : w_held_nxt[2] ? 4'b0100 :
                   w_held_nxt[0] ? 4'b0001 : w_held_nxt[1] ? 4'b0010 : 4'b0000;

   // newest arrow make takes the output; releasing a non-driven arrow leaves it alone
   always_ff @(posedge clk) begin
      if (resetN)
         r_drv <= '0;
      else if (w_hit && |w_key[3:0])
         r_drv <= !w_brk ? w_key[3:0] : |(r_drv & w_key[3:0]) ? w_fall : r_drv;
   end

   assign {upArrowPressed, downArrowPressed, rightArrowPressed, leftArrowPressed} = r_drv;
`else
   assign {upArrowPressed, downArrowPressed, rightArrowPressed, leftArrowPressed} = r_held[3:0];
`endif

   assign spacePressed = r_held[4];
   assign enterPressed = r_held[5];
   assign keyStrobe    = r_strobe;
endmodule

// File: tb/tb_kbd_arrow_decoder.sv
// tb_kbd_arrow_decoder: directed scenarios plus random byte streams checked against a behavioural key model
module tb_kbd_arrow_decoder;
   localparam int T = 50000;

   logic clk = 1'b0, resetN = 1'b1, din_new = 1'b0;
   logic [7:0] din = 8'h00;
   logic left, right, down, up, space, enter, strobe;
   int checks = 0, errors = 0;
   bit chk_en = 1'b0;

   kbd_arrow_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .resetN(resetN), .din_new(din_new), .din(din),
      .leftArrowPressed(left), .rightArrowPressed(right), .downArrowPressed(down),
      .upArrowPressed(up), .spacePressed(space), .enterPressed(enter), .keyStrobe(strobe));

   always #5 clk = ~clk;

   // model: pending prefix flags, idle gap, key-down table, driven arrow
   bit m_ext, m_brk, m_strobe;
   int m_gap;
   bit m_down[6];
   int m_drv = -1;

   function automatic int key_of(bit ext, logic [7:0] b);
      if (ext) return b == 8'h6B ? 0 : b == 8'h74 ? 1 : b == 8'h72 ? 2 : b == 8'h75 ? 3 : -1;
      return b == 8'h29 ? 4 : b == 8'h5A ? 5 : -1;
   endfunction

   task automatic m_apply(logic [7:0] b);
      int k;
      int pr[4] = '{3, 2, 0, 1};
      k = key_of(m_ext, b);
      if (k >= 0) begin
         m_strobe = 1'b1;
         m_down[k] = !m_brk;
         if (k < 4) begin
            if (!m_brk) m_drv = k;
            else if (m_drv == k) begin
               m_drv = -1;
               for (int i = 3; i >= 0; i--) if (m_down[pr[i]]) m_drv = pr[i];
            end
         end
      end
   endtask

   always @(posedge clk) begin
      m_strobe = 1'b0;
      if (resetN) begin
         m_ext = 0; m_brk = 0; m_gap = 0; m_drv = -1;
         for (int i = 0; i < 6; i++) m_down[i] = 0;
      end else if (din_new) begin
         m_gap = 0;
         if (!m_ext && !m_brk && din == 8'hE0) m_ext = 1;
         else if (!m_brk && din == 8'hF0) m_brk = 1;
         else begin
            m_apply(din);
            m_ext = 0; m_brk = 0;
         end
      end else if (m_ext || m_brk) begin
         m_gap++;
         if (m_gap >= T) begin m_ext = 0; m_brk = 0; m_gap = 0; end
      end
   end

   function automatic logic [6:0] model_vec();
      logic [3:0] a;
`ifdef KBD_ONE_HOT_EN
      for (int i = 0; i < 4; i++) a[i] = m_drv == i;
`else
      for (int i = 0; i < 4; i++) a[i] = m_down[i];
`endif
      return {a[0], a[1], a[2], a[3], m_down[4], m_down[5], m_strobe};
   endfunction

   function automatic logic [6:0] dut_vec();
      return {left, right, down, up, space, enter, strobe};
   endfunction

   task automatic check(string name, logic [6:0] got, logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {l,r,d,u,sp,en,stb}=%b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   // every-cycle comparison against the model
   always @(negedge clk) if (chk_en) check("model", dut_vec(), model_vec());

   task automatic send(logic [7:0] b);
      din_new = 1'b1; din = b;
      @(negedge clk);
      din_new = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      resetN = 1'b1;
      idle(2);
      resetN = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      chk_en = 1'b1;
      check("reset", dut_vec(), 7'b0000000);
      // E0,6B make left; then E0,F0,6B break it
      send(8'hE0);
      check("e0_nostrobe", dut_vec(), 7'b0000000);
      send(8'h6B);
      check("left_make", dut_vec(), 7'b1000001);
      idle(1);
      check("left_hold", dut_vec(), 7'b1000000);
      send(8'h6B); send(8'hE0); send(8'h6B);
      check("left_typematic", dut_vec(), 7'b1000001);
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("left_break", dut_vec(), 7'b0000001);
      // non-extended 75 is keypad 8, not up
      send(8'h75);
      check("kp8_ignored", dut_vec(), 7'b0000000);
      send(8'hE1); send(8'hAA);
      check("e1_aa_ignored", dut_vec(), 7'b0000000);
      send(8'hE0); send(8'h75);
      check("up_make", dut_vec(), 7'b0001001);
      send(8'h29);
      check("space_with_up", dut_vec(), 7'b0001101);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hF0); send(8'h29);
      check("all_released", dut_vec(), 7'b0000001);
      // right then up
      send(8'hE0); send(8'h74); send(8'hE0); send(8'h75);
`ifdef KBD_ONE_HOT_EN
      check("right_up", dut_vec(), 7'b0001001);
`else
      check("right_up", dut_vec(), 7'b0101001);
`endif
      send(8'hE0); send(8'hF0); send(8'h75);
      check("up_release", dut_vec(), 7'b0100001);
      send(8'hE0); send(8'hF0); send(8'h74);
      check("right_release", dut_vec(), 7'b0000001);
      // reset coincident with the final byte of E0,6B
      send(8'hE0);
      resetN = 1'b1; din_new = 1'b1; din = 8'h6B;
      @(negedge clk);
      din_new = 1'b0;
      idle(1);
      resetN = 1'b0;
      check("reset_wins", dut_vec(), 7'b0000000);
      send(8'h5A);
      check("enter_after_reset", dut_vec(), 7'b0000011);
      send(8'hF0); send(8'h5A);
      // abandoned prefix: E0 then a long silence then 29
      send(8'hE0);
      idle(60000);
      send(8'h29);
      check("timeout_space", dut_vec(), 7'b0000101);
      send(8'hF0); send(8'h29);
      check("timeout_cleanup", dut_vec(), 7'b0000001);
      // random streams weighted toward tracked codes and prefixes
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] pool[10] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'h5A, 8'hE1, 8'hAA};
         int r = $urandom_range(0, 11);
         send(r < 10 ? pool[r] : 8'($urandom));
         idle($urandom_range(0, 3));
         if ($urandom_range(0, 199) == 0) do_reset();
      end
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
